out_port_bcd: RTL and testbench
===============================

# out_port_bcd

Memory-mapped output port that captures CPU stores to its address and converts the stored value to packed BCD with a sequential shift-add-3 (double-dabble) engine. It sits in the CPU I/O subsystem between the data-memory bus and the seven-segment decoding stage. That stage takes `bcd` digits directly, so it needs no `/` or `%` hardware. One binary bit is converted per clock. The last completed result is held stable on `bcd` while a new conversion runs.

## Interface
Parameters:
- `PORT_ADDR`, default 6'b100000. Word address the port responds to; compared against `mem_addr[7:2]`, which is byte address 0x80.
- `NBITS`, fixed 16. Conversion operand width; produces 5 BCD digits.

Ports:
- `clock`, in, 1. Single clock; all state changes on its rising edge.
- `reset`, in, 1. Asynchronous, active-high.
- `mem_addr`, in, 32. CPU data address.
- `mem_datain`, in, 32. CPU store data.
- `mem_we`, in, 1. CPU store strobe.
- `port_out`, out, 32. Raw latched store value.
- `bcd`, out, 20. Five packed BCD digits; [3:0] is units, [19:16] is ten-thousands.
- `bcd_valid`, out, 1. High when `bcd` represents the current `port_out`.
- `busy`, out, 1. High while a conversion is in progress.

## Operation
- A write hit is `mem_we & (mem_addr[7:2] == PORT_ADDR)`. Bits [31:8] and [1:0] are ignored.
- The FSM has two states, IDLE and CONV.
- Write hit in any state:
  - `port_out <= mem_datain`.
  - Operand shift register `<=` operand (see Configuration).
  - Working BCD register `<= 0`, bit counter `<= 0`.
  - State `<= CONV`, `busy <= 1`, `bcd_valid <= 0`.
- CONV cycle without a write hit:
  - Each working digit ≥ 5 gets +3.
  - Then {working BCD, operand} shifts left one bit.
  - Counter increments.
- CONV completion: on the cycle the counter reaches 15, the shifted result is written to `bcd`. In the same cycle `bcd_valid <= 1`, `busy <= 0`, state `<= IDLE`.
- IDLE without a write hit: all registers hold.
- Write hit during CONV aborts the running conversion and restarts with the new data. The write has priority over the completion step, so an aborted result never reaches `bcd`.
- `bcd` changes only at completion or reset. It never shows intermediate digits.
- Truncation: the default operand is `mem_datain[15:0]`, i.e. the value mod 65536. Range is 0..65535, giving `bcd` 20'h00000..20'h65535.

## Timing
- Reset values: `port_out` = 0, `bcd` = 0, `bcd_valid` = 1, `busy` = 0, state IDLE, counter 0.
- `port_out` updates on the write-hit edge, edge W.
- `busy` is high and `bcd_valid` low from edge W through edge W+15.
- `bcd` takes the new value at edge W+16, the same edge where `busy` falls and `bcd_valid` rises.
- Total latency is 16 clocks from the write edge to a valid result.
- Back-to-back write hits: every hit restarts the 16-cycle count from its own edge.
- `reset` asserted mid-conversion returns everything to the reset values immediately, without waiting for a clock. The pending conversion is discarded.
- No combinational path from `mem_*` to any output; all outputs are registered.

## Configuration
- Macro `OUT_PORT_BCD_SAT_EN`.
- Defined: if `mem_datain[31:16] != 0`, the operand loaded is 16'hFFFF, so `bcd` becomes 20'h65535. Otherwise the operand is `mem_datain[15:0]`.
- Undefined: the operand is always `mem_datain[15:0]` (truncation). `port_out` always holds the full 32-bit value in both builds.

## Test plan
- Reset test: assert `reset` mid-clock → outputs go to 0 / 0 / 1 / 0 (`port_out` / `bcd` / `bcd_valid` / `busy`) before the next edge. Release reset, run 20 idle clocks → values unchanged.
- Write 42 to 0x80:
  - `port_out` = 42 at edge W.
  - `busy` = 1 for 16 clocks.
  - `bcd` = 20'h00000 until edge W+16, then 20'h00042 with `bcd_valid` = 1.
- Write 65535 → `bcd` = 20'h65535 at W+16. Then write 0 → `bcd` holds 20'h65535 for 16 clocks, then becomes 20'h00000.
- Address decode: write 7 to 0x84, and `mem_we` = 0 with address 0x80 → `port_out`, `bcd`, `busy` and `bcd_valid` all unchanged.
- Abort: write 123, then write 9876 at W+5 →
  - 20'h00123 never appears on `bcd`.
  - `bcd` = 20'h09876 at 16 edges after the second write.
  - `busy` stays continuously high between the two writes.
- Overflow: write 32'h0001_0005 → `bcd` = 20'h00005 without the macro, 20'h65535 with `OUT_PORT_BCD_SAT_EN`. `port_out` = 32'h0001_0005 in both builds.

Source files
------------

// File: rtl/out_port_bcd.sv
// Memory-mapped output port with a sequential double-dabble binary-to-BCD converter.
// Optional build macro OUT_PORT_BCD_SAT_EN: values above 16 bits saturate to 65535 instead of truncating.
module out_port_bcd #(
  parameter logic [5:0] PORT_ADDR = 6'b100000,
  parameter int         NBITS     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_datain,
  input  logic        mem_we,
  output logic [31:0] port_out,
  output logic [19:0] bcd,
  output logic        bcd_valid,
  output logic        busy
);

  localparam int NDIG = 5;
  localparam int BW   = 4 * NDIG;
  localparam int CW   = $clog2(NBITS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      port_out_q, port_out_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic [BW-1:0]    work_q, work_d;
  logic [NBITS-1:0] op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             write_hit;
  logic [NBITS-1:0] operand;
  logic [BW-1:0]    work_adj;
  logic [BW-1:0]    work_shifted;

  assign write_hit = mem_we && (mem_addr[7:2] == PORT_ADDR);

`ifdef OUT_PORT_BCD_SAT_EN
  assign operand = (|mem_datain[31:NBITS]) ? {NBITS{1'b1}} : mem_datain[NBITS-1:0];
`else
  assign operand = mem_datain[NBITS-1:0];
`endif

  // Only the word-address field selects the port; the remaining address bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:8], mem_addr[1:0], mem_datain[31:NBITS]};

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      work_adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                      : work_q[4*i +: 4];
    end
  end

  assign work_shifted = {work_adj[BW-2:0], op_q[NBITS-1]};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    port_out_d  = port_out_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    work_d      = work_q;
    op_d        = op_q;
    cnt_d       = cnt_q;

    // A store restarts the engine and takes priority over finishing an older conversion.
    if (write_hit) begin
      port_out_d  = mem_datain;
      op_d        = operand;
      work_d      = '0;
      cnt_d       = '0;
      state_d     = CONV;
      bcd_valid_d = 1'b0;
    end else if (state_q == CONV) begin
      work_d = work_shifted;
      op_d   = {op_q[NBITS-2:0], 1'b0};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CW'(NBITS - 1)) begin
        bcd_d       = work_shifted;
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
        cnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      port_out_q  <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b1;
      work_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      port_out_q  <= port_out_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      work_q      <= work_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
    end
  end

  assign port_out  = port_out_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q == CONV);

endmodule

// File: tb/tb_out_port_bcd.sv
// Directed self-checking bench for out_port_bcd: reset, conversion latency, decode, abort, overflow.
module tb_out_port_bcd;

  logic        clock;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic        mem_we;
  logic [31:0] port_out;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  out_port_bcd dut (
    .clock      (clock),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_datain (mem_datain),
    .mem_we     (mem_we),
    .port_out   (port_out),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] exp_port,
                            input logic [19:0] exp_bcd, input logic exp_valid,
                            input logic exp_busy);
    check({tag, ".port_out"},  port_out,          exp_port);
    check({tag, ".bcd"},       {12'h0, bcd},       {12'h0, exp_bcd});
    check({tag, ".bcd_valid"}, {31'h0, bcd_valid}, {31'h0, exp_valid});
    check({tag, ".busy"},      {31'h0, busy},      {31'h0, exp_busy});
  endtask

  // Drives one bus cycle; returns 1ns after the capturing edge W.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic we);
    @(negedge clock);
    mem_addr   = addr;
    mem_datain = data;
    mem_we     = we;
    @(posedge clock);
    #1;
    mem_we     = 1'b0;
  endtask

  // Called 1ns after edge W: checks the old result is held through W+15 and the new one lands at W+16.
  task automatic expect_result(input string tag, input logic [31:0] exp_port,
                               input logic [19:0] old_bcd, input logic [19:0] new_bcd);
    check_outs({tag, "@W"}, exp_port, old_bcd, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      #1;
      if (k < 16) check_outs($sformatf("%s@W+%0d", tag, k), exp_port, old_bcd, 1'b0, 1'b1);
      else        check_outs($sformatf("%s@W+16", tag), exp_port, new_bcd, 1'b1, 1'b0);
    end
  endtask

  task automatic idle_hold(input string tag, input int n, input logic [31:0] exp_port,
                           input logic [19:0] exp_bcd);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      check_outs($sformatf("%s[%0d]", tag, k), exp_port, exp_bcd, 1'b1, 1'b0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    mem_addr   = 32'h0;
    mem_datain = 32'h0;
    mem_we     = 1'b0;
    #1;
    check_outs("reset_init", 32'h0, 20'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle_hold("idle_after_reset", 20, 32'h0, 20'h0);

    store(32'h0000_0080, 32'd42, 1'b1);
    expect_result("w42", 32'd42, 20'h00000, 20'h00042);

    store(32'h0000_0080, 32'd65535, 1'b1);
    expect_result("w65535", 32'd65535, 20'h00042, 20'h65535);

    store(32'h0000_0080, 32'd0, 1'b1);
    expect_result("w0", 32'd0, 20'h65535, 20'h00000);

    store(32'h0000_0084, 32'd7, 1'b1);
    check_outs("decode_0x84", 32'd0, 20'h0, 1'b1, 1'b0);
    store(32'h0000_0080, 32'd7, 1'b0);
    check_outs("decode_we0", 32'd0, 20'h0, 1'b1, 1'b0);
    idle_hold("decode_idle", 3, 32'd0, 20'h0);

    // Upper and byte-offset address bits are ignored, so 0x...83 still hits the port.
    store(32'h1234_5683, 32'd1234, 1'b1);
    expect_result("w1234_alias", 32'd1234, 20'h00000, 20'h01234);

    store(32'h0000_0080, 32'd123, 1'b1);
    check_outs("abort_first@W", 32'd123, 20'h01234, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      check_outs($sformatf("abort_first@W+%0d", k), 32'd123, 20'h01234, 1'b0, 1'b1);
    end
    store(32'h0000_0080, 32'd9876, 1'b1);
    expect_result("abort_second", 32'd9876, 20'h01234, 20'h09876);
    idle_hold("abort_idle", 4, 32'd9876, 20'h09876);

    store(32'h0000_0080, 32'h0001_0005, 1'b1);
`ifdef OUT_PORT_BCD_SAT_EN
    expect_result("overflow", 32'h0001_0005, 20'h09876, 20'h65535);
`else
    expect_result("overflow", 32'h0001_0005, 20'h09876, 20'h00005);
`endif

    // Reset asserted between edges in the middle of a conversion.
    store(32'h0000_0080, 32'd500, 1'b1);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_outs("reset_midconv", 32'h0, 20'h0, 1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    idle_hold("idle_after_reset2", 20, 32'h0, 20'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
